vga_sync_receiver: RTL and testbench

- Sink-side counterpart of the VGA timing generator. Takes incoming hsync/vsync, rebuilds the pixel and line counters, measures line length and frame height, and reports lock.
- Used to check or slave downstream logic (scalers, capture, test monitors) against a 640x480@60 timing stream on the same pixel clock.

---
 rtl/vga_sync_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: rebuilds pixel/line counters from hsync/vsync, measures timing, reports lock.
// Optional feature macro VGA_RX_INPUT_SYNC_EN adds a 2-flop input synchronizer with compensated counter load.
module vga_sync_receiver #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       valid,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

`ifdef VGA_RX_INPUT_SYNC_EN
    // Two synchronizer stages delay the detected fall; load further ahead to stay zero-offset.
    localparam int HFALL_LOAD = (H_SYNC_START + 3) % H_TOTAL;
`else
    localparam int HFALL_LOAD = (H_SYNC_START + 1) % H_TOTAL;
`endif

    localparam logic [9:0]  SAT          = 10'd1023;
    localparam logic [9:0]  PX_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]  LN_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  PX_LOAD      = 10'(HFALL_LOAD);
    localparam logic [9:0]  HFALL_EXPECT = 10'((HFALL_LOAD + H_TOTAL - 1) % H_TOTAL);
    localparam logic [9:0]  LN_LOAD      = 10'(V_SYNC_START);
    localparam logic [9:0]  LN_EARLY     = 10'(V_SYNC_START - 1);
    localparam logic [9:0]  FRAME_LINES  = 10'(V_TOTAL);
    localparam logic [10:0] LCNT_MAX     = 11'(2 * H_TOTAL);

    logic hs_src, vs_src;

`ifdef VGA_RX_INPUT_SYNC_EN
    logic [1:0] hs_sync_q, vs_sync_q;

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hs_sync_q <= 2'b11;
            vs_sync_q <= 2'b11;
        end else begin
            hs_sync_q <= {hs_sync_q[0], hsync_in};
            vs_sync_q <= {vs_sync_q[0], vsync_in};
        end
    end

    assign hs_src = hs_sync_q[1];
    assign vs_src = vs_sync_q[1];
`else
    assign hs_src = hsync_in;
    assign vs_src = vsync_in;
`endif

    logic        hs_q, vs_q;
    logic [9:0]  px_q, px_d;
    logic [9:0]  ln_q, ln_d;
    logic [10:0] lcnt_q, lcnt_d;
    logic [9:0]  fcnt_q, fcnt_d;
    logic [9:0]  line_len_q, line_len_d;
    logic [9:0]  frame_lines_q, frame_lines_d;
    logic        sticky_q, sticky_d;
    logic        sync_err_q, sync_err_d;
    state_t      state_q, state_d;

    logic hfall, vfall, px_wrap;
    logic line_err, frame_err, timeout;

    assign hfall     = !hs_src && hs_q;
    assign vfall     = !vs_src && vs_q;
    assign px_wrap   = !hfall && (px_q == PX_LAST);
    assign line_err  = hfall && (px_q != HFALL_EXPECT);
    assign frame_err = vfall && (ln_q != LN_EARLY) && (ln_q != LN_LOAD);
    assign timeout   = (lcnt_q == LCNT_MAX);

    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        px_d          = px_q;
        ln_d          = ln_q;
        lcnt_d        = lcnt_q;
        fcnt_d        = fcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (hfall)
            px_d = PX_LOAD;
        else if (px_wrap)
            px_d = '0;
        else
            px_d = px_q + 10'd1;

        if (vfall)
            ln_d = LN_LOAD;
        else if (px_wrap)
            ln_d = (ln_q == LN_LAST) ? 10'd0 : ln_q + 10'd1;

        if (hfall) begin
            line_len_d = (lcnt_q >= 11'd1023) ? SAT : 10'(lcnt_q + 11'd1);
            lcnt_d     = '0;
        end else if (lcnt_q != LCNT_MAX) begin
            lcnt_d = lcnt_q + 11'd1;
        end

        // A same-cycle hfall belongs to the frame that this vfall opens.
        if (vfall) begin
            frame_lines_d = fcnt_q;
            fcnt_d        = hfall ? 10'd1 : 10'd0;
        end else if (hfall && fcnt_q != SAT) begin
            fcnt_d = fcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        sticky_d   = sticky_q;
        sync_err_d = 1'b0;

        case (state_q)
            SEARCH: begin
                if (vfall) begin
                    state_d  = ACQUIRE;
                    sticky_d = 1'b0;
                end
            end
            ACQUIRE: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else begin
                    sticky_d = sticky_q | line_err;
                    if (vfall) begin
                        if (!(sticky_q | line_err) && fcnt_q == FRAME_LINES)
                            state_d = LOCKED;
                        sticky_d = 1'b0;
                    end
                end
            end
            LOCKED: begin
                if (line_err || frame_err || timeout) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            px_q          <= '0;
            ln_q          <= '0;
            lcnt_q        <= '0;
            fcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            sticky_q      <= 1'b0;
            sync_err_q    <= 1'b0;
            state_q       <= SEARCH;
        end else begin
            hs_q          <= hs_src;
            vs_q          <= vs_src;
            px_q          <= px_d;
            ln_q          <= ln_d;
            lcnt_q        <= lcnt_d;
            fcnt_q        <= fcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            sticky_q      <= sticky_d;
            sync_err_q    <= sync_err_d;
            state_q       <= state_d;
        end
    end

    assign locked      = (state_q == LOCKED);
    assign valid       = locked && (px_q < 10'(H_ACTIVE)) && (ln_q < 10'(V_ACTIVE));
    assign h_cnt       = (px_q < 10'(H_ACTIVE)) ? px_q : 10'd0;
    assign v_cnt       = (ln_q < 10'(V_ACTIVE)) ? ln_q : 10'd0;
    assign frame_start = locked && (px_q == 10'd0) && (ln_q == 10'd0);
    assign sync_err    = sync_err_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a scaled-down timing generator (40x28 total).
module tb_vga_sync_receiver;

    localparam int HA = 32;
    localparam int HT = 40;
    localparam int HS = 34;
    localparam int HW = 4;
    localparam int VA = 24;
    localparam int VT = 28;
    localparam int VS = 26;
    localparam int VW = 2;
`ifdef VGA_RX_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int FRAME  = HT * VT;
    localparam int BUDGET = 3 * FRAME;

    logic       pclk  = 1'b0;
    logic       reset = 1'b0;
    logic       hsync_in, vsync_in;
    logic       valid, locked, frame_start, sync_err;
    logic [9:0] h_cnt, v_cnt, line_len, frame_lines;

    int   gpx = 0;
    int   gln = 0;
    logic hs_early  = 1'b0;
    logic hs_kill   = 1'b0;
    logic drop_line = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [9:0] h;
        logic [9:0] v;
        logic       fs;
        logic       serr;
    } exp_t;
    exp_t sb_q[$];

    always #5 pclk = ~pclk;

    // Reference timing generator: free-running, independent of the DUT reset.
    always @(posedge pclk) begin
        if (gpx == HT - 1) begin
            gpx <= 0;
            if (gln == VT - 1)
                gln <= 0;
            else if (drop_line && gln == 2)
                gln <= 4;
            else
                gln <= gln + 1;
        end else begin
            gpx <= gpx + 1;
        end
    end

    assign hsync_in = hs_kill | !((gpx >= (hs_early ? HS - 5 : HS)) && (gpx < HS + HW));
    assign vsync_in = !((gln >= VS) && (gln < VS + VW));

    vga_sync_receiver #(
        .H_ACTIVE    (HA),
        .H_TOTAL     (HT),
        .H_SYNC_START(HS),
        .V_ACTIVE    (VA),
        .V_TOTAL     (VT),
        .V_SYNC_START(VS)
    ) dut (
        .pclk       (pclk),
        .reset      (reset),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .valid      (valid),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .locked     (locked),
        .frame_start(frame_start),
        .sync_err   (sync_err),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    task automatic wait_pos(input int x, input int y);
        int n;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!(gpx == x && gln == y) && n < BUDGET);
        if (!(gpx == x && gln == y)) begin
            checks++;
            errors++;
            $display("FAIL wait_pos(%0d,%0d): position not reached within %0d cycles", x, y, BUDGET);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        checks++;
        if ({valid, h_cnt, v_cnt, locked, frame_start, sync_err, line_len, frame_lines} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {valid, h_cnt, v_cnt, locked, frame_start, sync_err, line_len, frame_lines});
        end
        @(negedge pclk);
        reset = 1'b1;
    endtask

    task automatic test_pre_lock_align();
        wait_pos(5, 1);
        checks++;
        if (h_cnt !== 10'd5 || locked !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL pre_lock_align: h_cnt=%0d locked=%b valid=%b expected 5/0/0", h_cnt, locked, valid);
        end
    endtask

    task automatic test_nominal();
        exp_t e, o;
        int   fs_cnt;
        int   nfail;
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL nominal_first_vfall: locked=%b expected 0", locked);
        end
        wait_pos(LAT, VS);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL nominal_before_lock: locked=%b expected 0", locked);
        end
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b1 || frame_lines !== 10'(VT) || line_len !== 10'(HT)) begin
            errors++;
            $display("FAIL nominal_lock: locked=%b frame_lines=%0d line_len=%0d expected 1/%0d/%0d",
                     locked, frame_lines, line_len, VT, HT);
        end
        wait_pos(0, 0);
        fs_cnt = 0;
        nfail  = 0;
        for (int i = 0; i < FRAME; i++) begin
            e.valid = (gpx < HA) && (gln < VA);
            e.h     = (gpx < HA) ? 10'(gpx) : 10'd0;
            e.v     = (gln < VA) ? 10'(gln) : 10'd0;
            e.fs    = (gpx == 0) && (gln == 0);
            e.serr  = 1'b0;
            sb_q.push_back(e);
            o = sb_q.pop_front();
            if (frame_start === 1'b1) fs_cnt++;
            checks++;
            if (valid !== o.valid || h_cnt !== o.h || v_cnt !== o.v || frame_start !== o.fs || sync_err !== o.serr) begin
                errors++;
                nfail++;
                if (nfail <= 5)
                    $display("FAIL scoreboard at gen(%0d,%0d): got v=%b h=%0d v=%0d fs=%b err=%b expected v=%b h=%0d v=%0d fs=%b err=%b",
                             gpx, gln, valid, h_cnt, v_cnt, frame_start, sync_err,
                             o.valid, o.h, o.v, o.fs, o.serr);
            end
            @(negedge pclk);
        end
        checks++;
        if (fs_cnt != 1 || line_len !== 10'(HT) || frame_lines !== 10'(VT)) begin
            errors++;
            $display("FAIL nominal_frame_stats: frame_starts=%0d line_len=%0d frame_lines=%0d expected 1/%0d/%0d",
                     fs_cnt, line_len, frame_lines, HT, VT);
        end
    endtask

    task automatic test_reset_mid_line();
        wait_pos(15, 5);
        reset = 1'b0;
        #1;
        checks++;
        if ({valid, h_cnt, v_cnt, locked, frame_start, sync_err, line_len, frame_lines} !== 44'd0) begin
            errors++;
            $display("FAIL mid_line_reset: got %h expected 0",
                     {valid, h_cnt, v_cnt, locked, frame_start, sync_err, line_len, frame_lines});
        end
        repeat (2) @(negedge pclk);
        reset = 1'b1;
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reacquire_first_vfall: locked=%b expected 0", locked);
        end
        wait_pos(LAT, VS);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL reacquire_before_second: locked=%b expected 0", locked);
        end
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL reacquire_lock: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_early_hsync();
        wait_pos(0, 3);
        hs_early = 1'b1;
        wait_pos(30 + LAT, 3);
        checks++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || line_len !== 10'(HT - 5)) begin
            errors++;
            $display("FAIL early_hsync: sync_err=%b locked=%b line_len=%0d expected 1/0/%0d",
                     sync_err, locked, line_len, HT - 5);
        end
        @(negedge pclk);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL early_hsync_pulse: sync_err=%b expected 0", sync_err);
        end
        wait_pos(38, 3);
        hs_early = 1'b0;
        wait_pos(35 + LAT, 4);
        checks++;
        if (line_len !== 10'(HT + 5)) begin
            errors++;
            $display("FAIL early_hsync_next_len: line_len=%0d expected %0d", line_len, HT + 5);
        end
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL early_relock_first: locked=%b expected 0", locked);
        end
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL early_relock: locked=%b expected 1", locked);
        end
    endtask

    task automatic test_timeout();
        wait_pos(0, 3);
        hs_kill = 1'b1;
        wait_pos(35 + LAT, 4);
        checks++;
        if (locked !== 1'b1 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: locked=%b sync_err=%b expected 1/0", locked, sync_err);
        end
        @(negedge pclk);
        checks++;
        if (locked !== 1'b0 || sync_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: locked=%b sync_err=%b expected 0/1", locked, sync_err);
        end
        @(negedge pclk);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: sync_err=%b expected 0", sync_err);
        end
        wait_pos(5, 5);
        hs_kill = 1'b0;
    endtask

    task automatic test_dropped_line();
        wait_pos(5, 10);
        reset = 1'b0;
        @(negedge pclk);
        reset = 1'b1;
        wait_pos(1 + LAT, VS);
        drop_line = 1'b1;
        wait_pos(1, 4);
        drop_line = 1'b0;
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b0 || frame_lines !== 10'(VT - 1)) begin
            errors++;
            $display("FAIL dropped_line: locked=%b frame_lines=%0d expected 0/%0d", locked, frame_lines, VT - 1);
        end
        wait_pos(1 + LAT, VS);
        checks++;
        if (locked !== 1'b1 || frame_lines !== 10'(VT)) begin
            errors++;
            $display("FAIL dropped_line_relock: locked=%b frame_lines=%0d expected 1/%0d", locked, frame_lines, VT);
        end
    endtask

    initial begin
        test_reset();
        test_pre_lock_align();
        test_nominal();
        test_reset_mid_line();
        test_early_hsync();
        test_timeout();
        test_dropped_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
